dcache_miss_ctrl: RTL and testbench

- Miss-handling controller for the one-way (direct-mapped), write-back data cache in the MEM stage of the 5-stage MIPS pipeline.
- On a MEM-stage access it takes the tag-compare result, sequences the optional dirty-victim write-back and the line refill over the beat-acknowledged memory interface, and drives the SRAM write strobe.
- Raises a pipeline-wide stall, consumed alongside the load-use hazard stall, until the access can retire as a hit.

---
 rtl/dcache_miss_ctrl.sv | 130 +++++++++++++
 tb/tb_dcache_miss_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dcache_miss_ctrl.sv
// Miss-handling FSM for the direct-mapped write-back D-cache: dirty-victim write-back,
// line refill, SRAM write strobe and pipeline stall. DCACHE_PERF_EN adds perf counters.
module dcache_miss_ctrl #(
  parameter int LINE_BEATS  = 1,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic        hit_i,
  input  logic        dirty_i,
  input  logic        mem_ack_i,
  output logic        mem_enable_o,
  output logic        mem_write_o,
  output logic        mem_addr_sel_o,
  output logic [3:0]  beat_o,
  output logic        cache_we_o,
  output logic        set_dirty_o,
  output logic        stall_o,
  output logic        err_o
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] miss_cnt_o,
  output logic [31:0] wb_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    REFILL    = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_BEAT = 4'(LINE_BEATS - 1);
  localparam logic [16:0] WD_LIMIT  = 17'(ACK_TIMEOUT);

  state_t      state, state_nxt;
  logic [3:0]  beat;
  logic [15:0] wd_cnt;
  logic        err;
  logic        busy, miss, last_ack, timeout;

  assign busy     = (state == WRITEBACK) || (state == REFILL);
  assign miss     = req_i & ~hit_i;
  assign last_ack = mem_ack_i && (beat == LAST_BEAT);
  // Fires on the ACK_TIMEOUT-th consecutive ack-less busy cycle; an ack in that cycle wins.
  assign timeout  = (ACK_TIMEOUT != 0) && busy && !mem_ack_i &&
                    (({1'b0, wd_cnt} + 17'd1) == WD_LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (miss) state_nxt = dirty_i ? WRITEBACK : REFILL;
      WRITEBACK: if (timeout) state_nxt = IDLE;
                 else if (last_ack) state_nxt = REFILL;
      REFILL:    if (timeout) state_nxt = IDLE;
                 else if (last_ack) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o   = 1'b0;
    mem_write_o    = 1'b0;
    mem_addr_sel_o = 1'b0;
    cache_we_o     = 1'b0;
    set_dirty_o    = 1'b0;
    case (state)
      IDLE: begin
        if (req_i && hit_i && write_i) begin
          cache_we_o  = 1'b1;
          set_dirty_o = 1'b1;
        end
      end
      WRITEBACK: begin
        mem_enable_o   = 1'b1;
        mem_write_o    = 1'b1;
        mem_addr_sel_o = 1'b1;
      end
      REFILL: begin
        mem_enable_o = 1'b1;
        cache_we_o   = mem_ack_i;
      end
      default: ;
    endcase
  end

  // Beat index, watchdog and sticky error
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      beat   <= 4'd0;
      wd_cnt <= 16'd0;
      err    <= 1'b0;
    end else begin
      if (timeout) err <= 1'b1;
      if (busy && !mem_ack_i && !timeout) wd_cnt <= wd_cnt + 16'd1;
      else                                 wd_cnt <= 16'd0;
      if (!busy || timeout) beat <= 4'd0;
      else if (mem_ack_i)   beat <= last_ack ? 4'd0 : beat + 4'd1;
    end
  end

  assign stall_o = (state != IDLE) | miss;
  assign beat_o  = beat;
  assign err_o   = err;

`ifdef DCACHE_PERF_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miss_cnt_o  <= 32'd0;
      wb_cnt_o    <= 32'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      if (state == IDLE && miss)            miss_cnt_o  <= miss_cnt_o + 32'd1;
      if (state == IDLE && miss && dirty_i) wb_cnt_o    <= wb_cnt_o + 32'd1;
      if (stall_o)                          stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl: instance a (LINE_BEATS=4, ACK_TIMEOUT=8) and
// instance b (LINE_BEATS=1, no watchdog) share stimulus; each step checks one of them.
module tb_dcache_miss_ctrl;

  logic clk, rst, req, wr, hit, dirty, ack;
  logic en_a, mw_a, sel_a, we_a, sd_a, stall_a, err_a;
  logic en_b, mw_b, sel_b, we_b, sd_b, stall_b, err_b;
  logic [3:0] beat_a, beat_b;
`ifdef DCACHE_PERF_EN
  logic [31:0] mc_a, wc_a, sc_a, mc_b, wc_b, sc_b;
`endif

  int n_chk = 0;
  int n_fail = 0;
  int stl, wes;

  dcache_miss_ctrl #(.LINE_BEATS(4), .ACK_TIMEOUT(8)) u_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .hit_i(hit), .dirty_i(dirty),
    .mem_ack_i(ack), .mem_enable_o(en_a), .mem_write_o(mw_a), .mem_addr_sel_o(sel_a),
    .beat_o(beat_a), .cache_we_o(we_a), .set_dirty_o(sd_a), .stall_o(stall_a), .err_o(err_a)
`ifdef DCACHE_PERF_EN
    , .miss_cnt_o(mc_a), .wb_cnt_o(wc_a), .stall_cnt_o(sc_a)
`endif
  );

  dcache_miss_ctrl #(.LINE_BEATS(1), .ACK_TIMEOUT(0)) u_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .write_i(wr), .hit_i(hit), .dirty_i(dirty),
    .mem_ack_i(ack), .mem_enable_o(en_b), .mem_write_o(mw_b), .mem_addr_sel_o(sel_b),
    .beat_o(beat_b), .cache_we_o(we_b), .set_dirty_o(sd_b), .stall_o(stall_b), .err_o(err_b)
`ifdef DCACHE_PERF_EN
    , .miss_cnt_o(mc_b), .wb_cnt_o(wc_b), .stall_cnt_o(sc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; req = 1'b0; wr = 1'b0; hit = 1'b0; dirty = 1'b0; ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_stall_a", stall_a, 1'b0);
    chk1("rst_en_a", en_a, 1'b0);
    chk32("rst_beat_a", 32'(beat_a), 32'd0);
    chk1("rst_err_a", err_a, 1'b0);
    chk1("rst_we_a", we_a, 1'b0);
    chk1("rst_stall_b", stall_b, 1'b0);
    chk1("rst_en_b", en_b, 1'b0);
    #2 rst = 1'b1;

    // Write hit in IDLE
    tick();
    req = 1'b1; wr = 1'b1; hit = 1'b1;
    #1;
    chk1("whit_we", we_a, 1'b1);
    chk1("whit_sd", sd_a, 1'b1);
    chk1("whit_stall", stall_a, 1'b0);
    chk1("whit_en", en_a, 1'b0);

    // Instance b: clean read miss, ack on the third refill cycle
    tick();
    req = 1'b1; wr = 1'b0; hit = 1'b0; dirty = 1'b0;
    stl = 0; wes = 0;
    for (int i = 0; i < 8; i++) begin
      ack = (i == 3);
      hit = (i >= 4);
      #1;
      if (stall_b) stl++;
      if (we_b) wes++;
      if (i == 3) begin
        chk32("rm_beat", 32'(beat_b), 32'd0);
        chk1("rm_en", en_b, 1'b1);
        chk1("rm_mw", mw_b, 1'b0);
        chk1("rm_sd", sd_b, 1'b0);
      end
      if (i == 5) chk1("rm_release", stall_b, 1'b0);
      tick();
    end
    chk32("rm_stall_cycles", 32'(stl), 32'd5);
    chk32("rm_we_pulses", 32'(wes), 32'd1);
    ack = 1'b0; req = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;

    // Instance a: dirty write miss, 4 beats each way, ack every 2nd cycle
    tick();
    req = 1'b1; wr = 1'b1; dirty = 1'b1; hit = 1'b0;
    for (int i = 0; i < 19; i++) begin
      ack = (i >= 1 && i <= 16 && (i % 2) == 0);
      hit = (i >= 17);
      #1;
      chk1($sformatf("wm%0d_en", i), en_a, (i >= 1 && i <= 16));
      chk1($sformatf("wm%0d_mw", i), mw_a, (i >= 1 && i <= 8));
      chk1($sformatf("wm%0d_sel", i), sel_a, (i >= 1 && i <= 8));
      chk32($sformatf("wm%0d_beat", i), 32'(beat_a),
            (i >= 1 && i <= 16) ? 32'(((i - 1) % 8) / 2) : 32'd0);
      chk1($sformatf("wm%0d_we", i), we_a,
           ((i >= 10 && i <= 16 && (i % 2) == 0) || i == 18));
      chk1($sformatf("wm%0d_sd", i), sd_a, (i == 18));
      chk1($sformatf("wm%0d_stall", i), stall_a, (i <= 17));
      tick();
    end
    req = 1'b0; wr = 1'b0; dirty = 1'b0; ack = 1'b0;
    chk1("wm_err", err_a, 1'b0);

    // Instance a: reset during refill beat 2
    req = 1'b1; hit = 1'b0;
    tick();
    ack = 1'b1;
    tick();
    tick();
    ack = 1'b0; req = 1'b0;
    #1;
    chk32("mid_beat_pre", 32'(beat_a), 32'd2);
    chk1("mid_en_pre", en_a, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mid_stall", stall_a, 1'b0);
    chk1("mid_en", en_a, 1'b0);
    chk32("mid_beat", 32'(beat_a), 32'd0);
    chk1("mid_we", we_a, 1'b0);
    #2 rst = 1'b1;

    // Instance a: watchdog expiry with no ack in refill
    tick();
    req = 1'b1; hit = 1'b0;
    #1;
    chk1("wd_miss_stall", stall_a, 1'b1);
    tick();
    req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      #1;
      chk1($sformatf("wd%0d_err", i), err_a, 1'b0);
      chk1($sformatf("wd%0d_en", i), en_a, 1'b1);
      chk1($sformatf("wd%0d_we", i), we_a, 1'b0);
      tick();
    end
    #1;
    chk1("wd_err", err_a, 1'b1);
    chk1("wd_en", en_a, 1'b0);
    chk1("wd_stall", stall_a, 1'b0);
    repeat (3) tick();
    req = 1'b1; hit = 1'b1; wr = 1'b0;
    #1;
    chk1("wd_err_sticky", err_a, 1'b1);
    chk1("wd_hit_stall", stall_a, 1'b0);
    req = 1'b0;
    rst = 1'b0;
    #1;
    chk1("wd_err_cleared", err_a, 1'b0);
    #2 rst = 1'b1;

    // Instance b: three misses, the second one dirty
    stl = 0;
    for (int m = 0; m < 3; m++) begin
      tick();
      req = 1'b1; hit = 1'b0; wr = 1'b0; dirty = (m == 1); ack = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 1) hit = 1'b1;
        #1;
        if (stall_b) stl++;
        tick();
      end
    end
    req = 1'b0; ack = 1'b0; dirty = 1'b0;
    chk32("perf_seq_stalls", 32'(stl), 32'd10);
`ifdef DCACHE_PERF_EN
    chk32("perf_miss", mc_b, 32'd3);
    chk32("perf_wb", wc_b, 32'd1);
    chk32("perf_stall", sc_b, 32'd10);
    chk32("perf_stall_obs", sc_b, 32'(stl));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no end expected end of test");
    $fatal(1);
  end

endmodule
